freq_ratio_detector: RTL and testbench

Measures the period of a divided-clock signal (e.g. a /2, /4, /8 or /16 tap from a ripple divider) in reference-clock cycles. It declares lock once the period is stable and reports the division ratio as log2. It sits on the receiving side of divider outputs, for divider self-check and clock-ratio discovery.

---
 rtl/freq_ratio_detector.sv | 137 +++++++++++++
 tb/tb_freq_ratio_detector.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/freq_ratio_detector.sv
// Period / lock detector for a divided clock sampled in the reference clock domain.
// Optional ratio decode enabled by defining FRD_RATIO_DECODE_EN.
module freq_ratio_detector #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic [2:0]       ratio_log2,
    output logic             no_signal
);

    localparam int               MW   = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]    LC   = MW'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] TO   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {SEARCH, MEASURE, TRACK} state_t;

    state_t           state, state_n;
    logic             s1, s2, s3, rise;
    logic [CNT_W-1:0] cnt, ref_q, ref_n, period_n;
    logic [MW-1:0]    match, match_n;
    logic             pv_n, locked_n, nosig_n;

    // Synchronizer is only cleared by the hard reset so clear cannot fabricate an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          cnt <= '0;
        else if (clear)      cnt <= '0;
        else if (rise)       cnt <= CNT_W'(1);
        else if (cnt != CMAX) cnt <= cnt + 1'b1;
    end

    always_comb begin
        state_n  = state;
        period_n = period;
        pv_n     = 1'b0;
        locked_n = locked;
        nosig_n  = no_signal;
        ref_n    = ref_q;
        match_n  = match;
        if (rise) nosig_n = 1'b0;
        case (state)
            SEARCH: begin
                if (rise) state_n = MEASURE;
            end
            MEASURE, TRACK: begin
                if (rise) begin
                    period_n = cnt;
                    pv_n     = 1'b1;
                    state_n  = TRACK;
                    if (state == TRACK && cnt == ref_q) begin
                        if (match < LC) match_n = match + 1'b1;
                        locked_n = (match_n == LC);
                    end else begin
                        ref_n    = cnt;
                        match_n  = MW'(1);
                        locked_n = (state == MEASURE) && (LOCK_COUNT == 1);
                    end
                end else if (cnt == TO) begin
                    // Edge wins over timeout; only a quiet TIMEOUT cycle drops lock.
                    nosig_n  = 1'b1;
                    locked_n = 1'b0;
                    match_n  = '0;
                    state_n  = SEARCH;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= SEARCH;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            no_signal    <= 1'b0;
            ref_q        <= '0;
            match        <= '0;
        end else if (clear) begin
            state        <= SEARCH;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            no_signal    <= 1'b0;
            ref_q        <= '0;
            match        <= '0;
        end else begin
            state        <= state_n;
            period       <= period_n;
            period_valid <= pv_n;
            locked       <= locked_n;
            no_signal    <= nosig_n;
            ref_q        <= ref_n;
            match        <= match_n;
        end
    end

`ifdef FRD_RATIO_DECODE_EN
    always_comb begin
        ratio_log2 = 3'd0;
        if (locked) begin
            case (period)
                CNT_W'(2):  ratio_log2 = 3'd1;
                CNT_W'(4):  ratio_log2 = 3'd2;
                CNT_W'(8):  ratio_log2 = 3'd3;
                CNT_W'(16): ratio_log2 = 3'd4;
                default:    ratio_log2 = 3'd0;
            endcase
        end
    end
`else
    assign ratio_log2 = 3'b000;
`endif

endmodule

// File: tb/tb_freq_ratio_detector.sv
// Randomized bench for freq_ratio_detector against an edge-timestamp reference model.
module tb_freq_ratio_detector;
    localparam int CNT_W = 8, LOCK_COUNT = 4, TIMEOUT = 200;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0, reset = 1'b1, clear = 1'b0, sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid, locked, no_signal;
    logic [2:0]       ratio_log2;

    freq_ratio_detector #(.CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .clear(clear), .sig_in(sig_in), .period(period),
        .period_valid(period_valid), .locked(locked), .ratio_log2(ratio_log2),
        .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0;

    // Model: rising edges become visible two samples late; a period is the
    // timestamp difference between consecutive visible edges.
    int kc, last_ts, edges_seen, ref_p, run;
    bit h1, h2, h3;
    int m_period;
    bit m_pv, m_locked, m_nosig;

    function automatic int exp_ratio(int p, bit l);
`ifdef FRD_RATIO_DECODE_EN
        if (!l) return 0;
        case (p)
            2: return 1; 4: return 2; 8: return 3; 16: return 4;
            default: return 0;
        endcase
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        last_ts = kc + 1; edges_seen = 0; ref_p = 0; run = 0;
        h1 = 0; h2 = 0; h3 = 0;
        m_period = 0; m_pv = 0; m_locked = 0; m_nosig = 0;
    endtask

    task automatic model_step(input bit s, input bit clr);
        int el;
        bit ev;
        kc++;
        el = kc - last_ts;
        if (el > CMAX) el = CMAX;
        ev = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = s;
        m_pv = 0;
        if (clr) begin
            edges_seen = 0; ref_p = 0; run = 0;
            m_period = 0; m_locked = 0; m_nosig = 0;
            last_ts = kc + 1;
        end else if (ev) begin
            m_nosig = 0;
            last_ts = kc;
            if (edges_seen >= 1) begin
                m_period = el; m_pv = 1;
                if (edges_seen >= 2 && el == ref_p) begin
                    run = (run < LOCK_COUNT) ? run + 1 : run;
                    m_locked = (run == LOCK_COUNT);
                end else begin
                    m_locked = (edges_seen == 1) && (LOCK_COUNT == 1);
                    ref_p = el; run = 1;
                end
            end
            if (edges_seen < 2) edges_seen++;
        end else if (edges_seen >= 1 && el == TIMEOUT) begin
            m_nosig = 1; m_locked = 0; run = 0; edges_seen = 0;
        end
    endtask

    // Called at a negedge; drives inputs, steps the model on the posedge, checks at +1.
    task automatic cyc(input bit s, input bit clr);
        sig_in = s; clear = clr;
        @(posedge clk);
        model_step(s, clr);
        #1;
        chk("period", 32'(period), 32'(m_period));
        chk("period_valid", 32'(period_valid), 32'(m_pv));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("no_signal", 32'(no_signal), 32'(m_nosig));
        chk("ratio_log2", 32'(ratio_log2), 32'(exp_ratio(m_period, m_locked)));
        @(negedge clk);
    endtask

    task automatic run_periodic(input int p, input int hi, input int n);
        for (int i = 0; i < n; i++) cyc((i % p) < hi, 1'b0);
    endtask

    task automatic run_level(input bit v, input int n);
        for (int i = 0; i < n; i++) cyc(v, 1'b0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_period"}, 32'(period), 0);
        chk({tag, "_pv"}, 32'(period_valid), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_nosig"}, 32'(no_signal), 0);
        chk({tag, "_ratio"}, 32'(ratio_log2), 0);
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1 check_idle("areset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        kc = 0;
        model_reset();
        #1 reset = 1'b0;
        #2 check_idle("reset");
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        run_periodic(2, 1, 30);
        chk("p2_period", 32'(period), 2);
        chk("p2_locked", 32'(locked), 1);
        chk("p2_ratio", 32'(ratio_log2), 32'(exp_ratio(2, 1)));

        run_periodic(16, int'($urandom_range(1, 15)), 16 * 7);
        chk("p16_period", 32'(period), 16);
        chk("p16_ratio", 32'(ratio_log2), 32'(exp_ratio(16, 1)));

        run_periodic(6, int'($urandom_range(1, 5)), 6 * 7);
        chk("p6_locked", 32'(locked), 1);
        chk("p6_ratio", 32'(ratio_log2), 0);

        run_periodic(4, 2, 4 * 8);
        chk("p4_ratio", 32'(ratio_log2), 32'(exp_ratio(4, 1)));
        run_periodic(8, int'($urandom_range(1, 7)), 8 * 6);
        chk("p8_locked", 32'(locked), 1);
        chk("p8_ratio", 32'(ratio_log2), 32'(exp_ratio(8, 1)));

        run_level(1'b0, 210);
        chk("to_nosig", 32'(no_signal), 1);
        chk("to_period", 32'(period), 8);
        chk("to_locked", 32'(locked), 0);
        run_periodic(8, 4, 8);
        chk("to_clr", 32'(no_signal), 0);

        run_periodic(4, 1, 4 * 8);
        cyc(1'b0, 1'b1);
        check_idle("clear");
        run_periodic(4, 3, 4 * 8);
        async_reset();
        run_periodic(8, 2, 8 * 7);
        chk("relock", 32'(locked), 1);

        for (int seg = 0; seg < 40; seg++) begin
            int kind, p;
            kind = int'($urandom_range(0, 9));
            if (kind < 5) begin
                p = 2 << $urandom_range(0, 3);
                run_periodic(p, int'($urandom_range(1, p - 1)), p * int'($urandom_range(3, 8)));
            end else if (kind < 7) begin
                p = int'($urandom_range(2, 24));
                run_periodic(p, int'($urandom_range(1, p - 1)), p * int'($urandom_range(3, 8)));
            end else if (kind == 7) begin
                for (int i = 0; i < 30; i++) cyc(1'($urandom_range(0, 1)), 1'b0);
            end else if (kind == 8) begin
                run_level(1'($urandom_range(0, 1)), int'($urandom_range(195, 215)));
            end else begin
                if ($urandom_range(0, 1) == 0) cyc(1'($urandom_range(0, 1)), 1'b1);
                else async_reset();
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
